// File: rtl/dm_access_ctrl.sv
// Load/store sequencer between the CPU memory stage and the 4 KB byte-addressable data memory.
// Halfword accesses are split into two byte accesses because the memory only does word and byte ops.
module dm_access_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [11:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [11:0] mem_addr,
    output logic [31:0] mem_din,
    output logic [2:0]  mem_we,
    input  logic [31:0] mem_dout
);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_SW  = 3'b001;
    localparam logic [2:0] OP_LB  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b011;
    localparam logic [2:0] OP_LH  = 3'b100;
    localparam logic [2:0] OP_SB  = 3'b101;
    localparam logic [2:0] OP_LHU = 3'b110;
    localparam logic [2:0] OP_SH  = 3'b111;

    localparam logic [2:0] MEM_RD_W  = 3'b000;
    localparam logic [2:0] MEM_WR_W  = 3'b001;
    localparam logic [2:0] MEM_RD_BS = 3'b010;
    localparam logic [2:0] MEM_RD_BU = 3'b011;
    localparam logic [2:0] MEM_WR_B  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC0 = 2'b01,
        ACC1 = 2'b10,
        RESP = 2'b11
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [2:0]  r_op;
    logic [11:0] r_addr;
    logic [31:0] r_wdata;
    logic [7:0]  r_lo;

    logic [11:0] r_mem_addr;
    logic [31:0] r_mem_din;
    logic [2:0]  r_mem_we;
    logic [31:0] r_rdata;
    logic        r_err;

    logic [11:0] w_mem_addr;
    logic [31:0] w_mem_din;
    logic [2:0]  w_mem_we;
    logic [31:0] w_rdata;
    logic        w_err;
    logic        w_accept;

    function automatic logic is_word(input logic [2:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic is_half(input logic [2:0] op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

    function automatic logic is_store(input logic [2:0] op);
        return (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
    endfunction

    // Access code for the first (or only) memory cycle; halfword loads read raw bytes.
    function automatic logic [2:0] first_code(input logic [2:0] op);
        logic [2:0] code;
        case (op)
            OP_SW:         code = MEM_WR_W;
            OP_LB:         code = MEM_RD_BS;
            OP_LBU:        code = MEM_RD_BU;
            OP_LH, OP_LHU: code = MEM_RD_BU;
            OP_SB, OP_SH:  code = MEM_WR_B;
            default:       code = MEM_RD_W;
        endcase
        return code;
    endfunction

    function automatic logic [31:0] first_din(input logic [2:0] op, input logic [31:0] wdata);
        logic [31:0] din;
        case (op)
            OP_SW:        din = wdata;
            OP_SB, OP_SH: din = {24'b0, wdata[7:0]};
            default:      din = 32'b0;
        endcase
        return din;
    endfunction

    function automatic logic [31:0] half_result(input logic [2:0] op, input logic [7:0] hi,
                                                input logic [7:0] lo);
        logic [31:0] res;
        if (op == OP_LH) res = {{16{hi[7]}}, hi, lo};
        else             res = {16'b0, hi, lo};
        return res;
    endfunction

    // Memory-side signals are computed for the state being entered and registered on the same edge.
    always_comb begin
        w_next     = r_state;
        w_mem_addr = r_mem_addr;
        w_mem_din  = r_mem_din;
        w_mem_we   = MEM_RD_W;
        w_rdata    = r_rdata;
        w_err      = r_err;
        w_accept   = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (is_word(req_op) && (req_addr[1:0] != 2'b00)) begin
                        w_next  = RESP;
                        w_err   = 1'b1;
                        w_rdata = 32'b0;
                    end else begin
                        w_next     = ACC0;
                        w_mem_addr = req_addr;
                        w_mem_we   = first_code(req_op);
                        w_mem_din  = first_din(req_op, req_wdata);
                    end
                end
            end
            ACC0: begin
                if (is_half(r_op)) begin
                    w_next     = ACC1;
                    w_mem_addr = r_addr + 12'd1;
                    if (r_op == OP_SH) begin
                        w_mem_we  = MEM_WR_B;
                        w_mem_din = {24'b0, r_wdata[15:8]};
                    end else begin
                        w_mem_we  = MEM_RD_BU;
                        w_mem_din = 32'b0;
                    end
                end else begin
                    w_next  = RESP;
                    w_err   = 1'b0;
                    w_rdata = is_store(r_op) ? 32'b0 : mem_dout;
                end
            end
            ACC1: begin
                w_next  = RESP;
                w_err   = 1'b0;
                w_rdata = is_store(r_op) ? 32'b0 : half_result(r_op, mem_dout[7:0], r_lo);
            end
            RESP: begin
                w_next  = IDLE;
                w_rdata = 32'b0;
                w_err   = 1'b0;
            end
            default: w_next = IDLE;
        endcase
    end

    // Async reset clears mem_we immediately so an aborted store cannot complete.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_mem_addr <= 12'b0;
            r_mem_din  <= 32'b0;
            r_mem_we   <= MEM_RD_W;
            r_rdata    <= 32'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_mem_addr <= w_mem_addr;
            r_mem_din  <= w_mem_din;
            r_mem_we   <= w_mem_we;
            r_rdata    <= w_rdata;
            r_err      <= w_err;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op    <= req_op;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
        if (r_state == ACC0) begin
            r_lo <= mem_dout[7:0];
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign mem_addr   = r_mem_addr;
    assign mem_din    = r_mem_din;
    assign mem_we     = r_mem_we;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: byte-array data memory plus a byte-level reference model of load/store semantics.
module tb_dm_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [11:0] mem_addr;
    logic [31:0] mem_din;
    logic [2:0]  mem_we;
    logic [31:0] mem_dout;

    int n_checks = 0;
    int n_errors = 0;
    int n_word_wr = 0;

    logic [7:0] mem     [0:4095] = '{default: 8'h00};
    logic [7:0] ref_mem [0:4095] = '{default: 8'h00};

    logic [11:0] wbase;
    logic [7:0]  rbyte;

    dm_access_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_we     (mem_we),
        .mem_dout   (mem_dout)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read, writes commit on the falling edge.
    always_comb begin
        wbase    = {mem_addr[11:2], 2'b00};
        rbyte    = mem[mem_addr];
        mem_dout = 32'h0;
        case (mem_we)
            3'b000:  mem_dout = {mem[wbase + 12'd3], mem[wbase + 12'd2], mem[wbase + 12'd1], mem[wbase]};
            3'b010:  mem_dout = {{24{rbyte[7]}}, rbyte};
            3'b011:  mem_dout = {24'b0, rbyte};
            default: mem_dout = 32'h0;
        endcase
    end

    always @(negedge clk) begin
        if (mem_we == 3'b001) begin
            mem[wbase]          <= mem_din[7:0];
            mem[wbase + 12'd1]  <= mem_din[15:8];
            mem[wbase + 12'd2]  <= mem_din[23:16];
            mem[wbase + 12'd3]  <= mem_din[31:24];
            n_word_wr           <= n_word_wr + 1;
        end else if (mem_we == 3'b101) begin
            mem[mem_addr] <= mem_din[7:0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference semantics of one request, applied to ref_mem.
    task automatic ref_access(input logic [2:0] op, input logic [11:0] a, input logic [31:0] wd,
                              output logic [31:0] rd, output logic err, output int lat);
        logic [11:0] a1;
        logic [7:0]  lo, hi;
        a1  = a + 12'd1;
        rd  = 32'h0;
        err = 1'b0;
        lat = 2;
        if ((op == 3'd0 || op == 3'd1) && a[1:0] != 2'b00) begin
            err = 1'b1;
            lat = 1;
            return;
        end
        lo = ref_mem[a];
        hi = ref_mem[a1];
        case (op)
            3'd0: rd = {ref_mem[a + 12'd3], ref_mem[a + 12'd2], hi, lo};
            3'd1: begin
                ref_mem[a]          = wd[7:0];
                ref_mem[a + 12'd1]  = wd[15:8];
                ref_mem[a + 12'd2]  = wd[23:16];
                ref_mem[a + 12'd3]  = wd[31:24];
            end
            3'd2: rd = {{24{lo[7]}}, lo};
            3'd3: rd = {24'h0, lo};
            3'd4: begin rd = {{16{hi[7]}}, hi, lo}; lat = 3; end
            3'd5: ref_mem[a] = wd[7:0];
            3'd6: begin rd = {16'h0, hi, lo}; lat = 3; end
            default: begin
                ref_mem[a]  = wd[7:0];
                ref_mem[a1] = wd[15:8];
                lat = 3;
            end
        endcase
    endtask

    task automatic run_req(input string tag, input logic [2:0] op, input logic [11:0] addr,
                           input logic [31:0] wd, output logic [31:0] rd_out);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          lat;
        logic        accepted;
        ref_access(op, addr, wd, exp_rd, exp_err, exp_lat);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        accepted  = 1'b0;
        for (int i = 0; i < 10 && !accepted; i++) begin
            if (req_ready) begin
                @(posedge clk);
                accepted = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        #1 req_valid = 1'b0;
        chk({tag, "_accept"}, {31'b0, accepted}, 32'd1);
        lat    = 99;
        rd_out = 32'hx;
        for (int n = 1; n <= 8 && lat == 99; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat    = n;
                rd_out = resp_rdata;
                chk({tag, "_rdata"}, resp_rdata, exp_rd);
                chk({tag, "_err"}, {31'b0, resp_err}, {31'b0, exp_err});
            end
        end
        chk({tag, "_lat"}, lat, exp_lat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        rv_seen;
        int          wcnt;
        int          diff;
        logic [2:0]  op;
        logic [11:0] addr;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'b0;
        req_addr  = 12'h0;
        req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", {31'b0, resp_err}, 32'd0);
        chk("rst_mem_addr", {20'b0, mem_addr}, 32'h0);
        chk("rst_mem_din", mem_din, 32'h0);
        chk("rst_mem_we", {29'b0, mem_we}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        run_req("sw010", 3'd1, 12'h010, 32'hDEADBEEF, rd);
        run_req("lw010", 3'd0, 12'h010, 32'h0, rd);
        chk("lw010_const", rd, 32'hDEADBEEF);
        run_req("lb013", 3'd2, 12'h013, 32'h0, rd);
        chk("lb013_const", rd, 32'hFFFFFFDE);
        run_req("lbu013", 3'd3, 12'h013, 32'h0, rd);
        chk("lbu013_const", rd, 32'h000000DE);
        run_req("lb011", 3'd2, 12'h011, 32'h0, rd);
        chk("lb011_const", rd, 32'hFFFFFFBE);
        run_req("sb012", 3'd5, 12'h012, 32'hAAAAAA55, rd);
        run_req("lw010b", 3'd0, 12'h010, 32'h0, rd);
        chk("lw010b_const", rd, 32'hDE55BEEF);
        run_req("sh013", 3'd7, 12'h013, 32'hFFFF8001, rd);
        run_req("lw010c", 3'd0, 12'h010, 32'h0, rd);
        chk("lw010c_b3", {24'b0, rd[31:24]}, 32'h01);
        run_req("lw014", 3'd0, 12'h014, 32'h0, rd);
        chk("lw014_b0", {24'b0, rd[7:0]}, 32'h80);
        run_req("lh013", 3'd4, 12'h013, 32'h0, rd);
        chk("lh013_const", rd, 32'hFFFF8001);
        run_req("lhu013", 3'd6, 12'h013, 32'h0, rd);
        chk("lhu013_const", rd, 32'h00008001);
        run_req("shfff", 3'd7, 12'hFFF, 32'h00001234, rd);
        chk("shfff_lo", {24'b0, mem[12'hFFF]}, 32'h34);
        chk("shfff_hi", {24'b0, mem[12'h000]}, 32'h12);
        run_req("lhufff", 3'd6, 12'hFFF, 32'h0, rd);
        chk("lhufff_const", rd, 32'h00001234);

        wcnt = n_word_wr;
        run_req("sw006", 3'd1, 12'h006, 32'hCAFEF00D, rd);
        chk("sw006_nowrite", n_word_wr, wcnt);
        run_req("lw001", 3'd0, 12'h001, 32'h0, rd);

        // Reset during the second byte of a halfword store.
        run_req("sb021", 3'd5, 12'h021, 32'h77, rd);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 3'd7;
        req_addr  = 12'h020;
        req_wdata = 32'h0000ABCD;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_mem_we", {29'b0, mem_we}, 32'h0);
        chk("abort_mem_addr", {20'b0, mem_addr}, 32'h0);
        chk("abort_mem_din", mem_din, 32'h0);
        chk("abort_ready", {31'b0, req_ready}, 32'd1);
        chk("abort_rdata", resp_rdata, 32'h0);
        ref_mem[12'h020] = 8'hCD;
        rv_seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            rv_seen = rv_seen | resp_valid;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            rv_seen = rv_seen | resp_valid;
        end
        chk("abort_no_resp", {31'b0, rv_seen}, 32'd0);
        chk("abort_byte021", {24'b0, mem[12'h021]}, 32'h77);
        run_req("post_lbu021", 3'd3, 12'h021, 32'h0, rd);
        run_req("post_lw020", 3'd0, 12'h020, 32'h0, rd);

        for (int k = 0; k < 60; k++) begin
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) addr = 12'($urandom_range(0, 31));
            else                           addr = 12'($urandom_range(4064, 4095));
            if ((op == 3'd0 || op == 3'd1) && $urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            run_req($sformatf("rnd%0d", k), op, addr, $urandom, rd);
        end

        diff = 0;
        for (int i = 0; i < 4096; i++) begin
            if (mem[i] !== ref_mem[i]) diff++;
        end
        chk("mem_image", diff, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
